// File: rtl/timer_pkg.sv
// timer_pkg: shared state encoding and BCD constants for the countdown timer loader.
package timer_pkg;
    typedef enum logic [2:0] {IDLE, ENTRY, LOAD, RUN, BEEP} state_t;
    typedef logic [3:0] bcd_t;
    localparam bcd_t BCD_MAX      = 4'd9;
    localparam bcd_t SEC_TENS_MAX = 4'd5;
endpackage

// File: rtl/bcd_normalize.sv
// bcd_normalize: folds MM:SS seconds-tens above 5 into minutes, saturating at 99:59.
module bcd_normalize
    import timer_pkg::*;
(
    input  logic [15:0] din,
    output logic [15:0] dout
);
    bcd_t m1, m0, s1, s0;
    logic over, sat;
    assign {m1, m0, s1, s0} = din;
    assign over = s1 > SEC_TENS_MAX;
    assign sat  = over && m1 == BCD_MAX && m0 == BCD_MAX;
    always_comb begin
        dout = din;
        if (sat)
            dout = 16'h9959;
        else if (over)
            dout = {m0 == BCD_MAX ? m1 + 4'd1 : m1, m0 == BCD_MAX ? 4'd0 : m0 + 4'd1, s1 - 4'd6, s0};
    end
endmodule

// File: rtl/timer_loader.sv
// timer_loader: keypad MM:SS entry, chain load strobe, 1 Hz count gating and beep phase.
// Optional TIMER_LOADER_NORMALIZE_EN folds seconds-tens > 5 into minutes instead of rejecting.
module timer_loader
    import timer_pkg::*;
#(
    parameter int BEEP_TICKS = 3
) (
    input  logic        clk,
    input  logic        clr,
    input  logic [3:0]  digit,
    input  logic        digit_valid,
    input  logic        start,
    input  logic        cancel,
    input  logic        tick,
    input  logic        timer_zero,
    output logic [15:0] data,
    output logic        loadn,
    output logic        en,
    output logic        busy,
    output logic        done,
    output logic        err
);
    state_t      state;
    logic [15:0] dbuf, load_val;
    logic [3:0]  bcnt;
    logic        key_ok, reject, go;
    assign key_ok = digit_valid && digit <= BCD_MAX;
    assign go     = start && dbuf != 16'h0;
    assign data   = dbuf;
    assign en     = state == RUN && tick && !timer_zero;
`ifdef TIMER_LOADER_NORMALIZE_EN
    bcd_normalize u_norm (.din(dbuf), .dout(load_val));
    assign reject = 1'b0;
`else
    assign load_val = dbuf;
    assign reject   = dbuf[7:4] > SEC_TENS_MAX;
`endif
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state <= IDLE;
            dbuf  <= 16'h0;
            bcnt  <= 4'd0;
            loadn <= 1'b1;
            busy  <= 1'b0;
            done  <= 1'b0;
            err   <= 1'b0;
        end else begin
            err   <= 1'b0;
            loadn <= 1'b1;
            case (state)
                IDLE: if (key_ok && !cancel) begin
                    dbuf  <= {dbuf[11:0], digit};
                    state <= ENTRY;
                end
                ENTRY: if (cancel) begin
                    dbuf  <= 16'h0;
                    state <= IDLE;
                end else if (go && reject) begin
                    err <= 1'b1;
                end else if (go) begin
                    dbuf  <= load_val;
                    loadn <= 1'b0;
                    busy  <= 1'b1;
                    state <= LOAD;
                end else if (key_ok) begin
                    dbuf <= {dbuf[11:0], digit};
                end
                LOAD: state <= RUN;
                // timer_zero wins over cancel so an expiring count always beeps
                RUN: if (timer_zero) begin
                    bcnt  <= 4'd0;
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= BEEP;
                end else if (cancel) begin
                    dbuf  <= 16'h0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                BEEP: if (cancel || key_ok || (tick && bcnt == 4'(BEEP_TICKS - 1))) begin
                    dbuf  <= 16'h0;
                    bcnt  <= 4'd0;
                    done  <= 1'b0;
                    state <= IDLE;
                end else if (tick) begin
                    bcnt <= bcnt + 4'd1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_timer_loader.sv
// tb_timer_loader: directed scenarios against timer_loader with a behavioural MM:SS countdown chain.
module tb_timer_loader;
    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic [3:0]  digit = 4'd0;
    logic        digit_valid = 1'b0, start = 1'b0, cancel = 1'b0, tick = 1'b0;
    logic        force_tz = 1'b0;
    logic        timer_zero;
    logic [15:0] data;
    logic        loadn, en, busy, done, err;
    logic [15:0] chain = 16'h0;
    int          checks = 0, errors = 0;

    timer_loader #(.BEEP_TICKS(3)) dut (
        .clk(clk), .clr(clr), .digit(digit), .digit_valid(digit_valid),
        .start(start), .cancel(cancel), .tick(tick), .timer_zero(timer_zero),
        .data(data), .loadn(loadn), .en(en), .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] dec(input logic [15:0] v);
        logic [3:0] m1, m0, s1, s0;
        {m1, m0, s1, s0} = v;
        if (s0 != 0) s0 = s0 - 1;
        else begin
            s0 = 9;
            if (s1 != 0) s1 = s1 - 1;
            else begin
                s1 = 5;
                if (m0 != 0) m0 = m0 - 1;
                else begin
                    m0 = 9;
                    m1 = m1 - 1;
                end
            end
        end
        return {m1, m0, s1, s0};
    endfunction

    always @(posedge clk)
        if (!loadn) chain <= data;
        else if (en) chain <= dec(chain);

    assign timer_zero = force_tz | (chain == 16'h0);

    task automatic cyc;
        @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [3:0] d);
        digit = d;
        digit_valid = 1'b1;
        cyc();
        digit_valid = 1'b0;
    endtask

    task automatic pulse_start;
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    task automatic pulse_cancel;
        cancel = 1'b1;
        cyc();
        cancel = 1'b0;
    endtask

    task automatic test_reset;
        cyc();
        cyc();
        checks++;
        if ({data, loadn, en, busy, done, err} !== {16'h0, 5'b10000}) begin
            errors++;
            $display("FAIL reset: got data=%h loadn=%b en=%b busy=%b done=%b err=%b, expected 0000 1 0 0 0 0",
                     data, loadn, en, busy, done, err);
        end
        clr = 1'b0;
        cyc();
    endtask

    task automatic test_load_run;
        logic [15:0] exp_buf [3] = '{16'h0001, 16'h0013, 16'h0130};
        logic [3:0]  keys [3] = '{4'd1, 4'd3, 4'd0};
        for (int i = 0; i < 3; i++) begin
            press(keys[i]);
            checks++;
            if (data !== exp_buf[i]) begin
                errors++;
                $display("FAIL entry_%0d: data=%h expected %h", i, data, exp_buf[i]);
            end
        end
        pulse_start();
        checks++;
        if ({loadn, busy, data} !== {2'b01, 16'h0130}) begin
            errors++;
            $display("FAIL load_strobe: loadn=%b busy=%b data=%h expected 0 1 0130", loadn, busy, data);
        end
        cyc();
        checks++;
        if ({loadn, busy, chain} !== {2'b11, 16'h0130}) begin
            errors++;
            $display("FAIL load_done: loadn=%b busy=%b chain=%h expected 1 1 0130", loadn, busy, chain);
        end
        tick = 1'b1;
        #1;
        checks++;
        if (en !== 1'b1) begin
            errors++;
            $display("FAIL run_en: en=%b expected 1", en);
        end
        repeat (89) cyc();
        checks++;
        if (chain !== 16'h0001 || timer_zero !== 1'b0) begin
            errors++;
            $display("FAIL run_89: chain=%h tz=%b expected 0001 0", chain, timer_zero);
        end
        cyc();
        checks++;
        if ({timer_zero, en, busy, done} !== 4'b1010) begin
            errors++;
            $display("FAIL zero_en: tz=%b en=%b busy=%b done=%b expected 1 0 1 0", timer_zero, en, busy, done);
        end
        tick = 1'b0;
        cyc();
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL beep_enter: done=%b busy=%b expected 1 0", done, busy);
        end
        tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (done !== (i < 2)) begin
                errors++;
                $display("FAIL beep_tick_%0d: done=%b expected %b", i, done, i < 2);
            end
        end
        tick = 1'b0;
    endtask

    task automatic test_cancel_entry;
        for (int i = 1; i <= 5; i++) press(4'(i));
        checks++;
        if (data !== 16'h2345) begin
            errors++;
            $display("FAIL five_keys: data=%h expected 2345", data);
        end
        pulse_cancel();
        checks++;
        if ({data, busy} !== 17'h0) begin
            errors++;
            $display("FAIL cancel_clear: data=%h busy=%b expected 0000 0", data, busy);
        end
        pulse_start();
        checks++;
        if ({loadn, busy} !== 2'b10) begin
            errors++;
            $display("FAIL idle_start: loadn=%b busy=%b expected 1 0", loadn, busy);
        end
    endtask

    task automatic test_invalid_key;
        press(4'd12);
        pulse_start();
        checks++;
        if ({data, loadn, busy, err} !== {16'h0, 3'b100}) begin
            errors++;
            $display("FAIL invalid_key: data=%h loadn=%b busy=%b err=%b expected 0000 1 0 0", data, loadn, busy, err);
        end
        press(4'd2);
        press(4'd11);
        checks++;
        if (data !== 16'h0002) begin
            errors++;
            $display("FAIL invalid_in_entry: data=%h expected 0002", data);
        end
        pulse_cancel();
    endtask

    task automatic test_bad_seconds;
        press(4'd9);
        press(4'd0);
        pulse_start();
`ifdef TIMER_LOADER_NORMALIZE_EN
        checks++;
        if ({loadn, err, data} !== {2'b00, 16'h0130}) begin
            errors++;
            $display("FAIL normalize: loadn=%b err=%b data=%h expected 0 0 0130", loadn, err, data);
        end
`else
        checks++;
        if ({loadn, err, busy, data} !== {3'b110, 16'h0090}) begin
            errors++;
            $display("FAIL reject: loadn=%b err=%b busy=%b data=%h expected 1 1 0 0090", loadn, err, busy, data);
        end
        cyc();
        checks++;
        if ({loadn, err} !== 2'b10) begin
            errors++;
            $display("FAIL reject_pulse: loadn=%b err=%b expected 1 0", loadn, err);
        end
`endif
        pulse_cancel();
        pulse_cancel();
        checks++;
        if ({data, busy} !== 17'h0) begin
            errors++;
            $display("FAIL bad_sec_exit: data=%h busy=%b expected 0000 0", data, busy);
        end
    endtask

    task automatic test_zero_beats_cancel;
        press(4'd4);
        pulse_start();
        cyc();
        force_tz = 1'b1;
        cancel = 1'b1;
        cyc();
        force_tz = 1'b0;
        cancel = 1'b0;
        checks++;
        if ({done, busy} !== 2'b10) begin
            errors++;
            $display("FAIL tz_vs_cancel: done=%b busy=%b expected 1 0", done, busy);
        end
        tick = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++;
            if (done !== (i < 2)) begin
                errors++;
                $display("FAIL beep2_tick_%0d: done=%b expected %b", i, done, i < 2);
            end
        end
        tick = 1'b0;
        checks++;
        if (data !== 16'h0) begin
            errors++;
            $display("FAIL beep_exit_buf: data=%h expected 0000", data);
        end
    endtask

    task automatic test_beep_key_exit;
        press(4'd5);
        pulse_start();
        cyc();
        force_tz = 1'b1;
        cyc();
        force_tz = 1'b0;
        press(4'd7);
        checks++;
        if ({done, data} !== {1'b0, 16'h0}) begin
            errors++;
            $display("FAIL beep_key: done=%b data=%h expected 0 0000", done, data);
        end
    endtask

    task automatic test_clr_run;
        press(4'd1);
        press(4'd3);
        press(4'd0);
        pulse_start();
        cyc();
        tick = 1'b1;
        #1;
        checks++;
        if ({en, busy} !== 2'b11) begin
            errors++;
            $display("FAIL pre_clr: en=%b busy=%b expected 1 1", en, busy);
        end
        clr = 1'b1;
        #1;
        checks++;
        if ({en, busy, loadn, data} !== {3'b001, 16'h0}) begin
            errors++;
            $display("FAIL clr_run: en=%b busy=%b loadn=%b data=%h expected 0 0 1 0000", en, busy, loadn, data);
        end
        tick = 1'b0;
        cyc();
        clr = 1'b0;
        cyc();
    endtask

    initial begin
        test_reset();
        test_load_run();
        test_cancel_entry();
        test_invalid_key();
        test_bad_seconds();
        test_zero_beats_cancel();
        test_beep_key_exit();
        test_clr_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
